// File: rtl/bcd_binario_seq.sv
// bcd_binario_seq: sequential 4-digit BCD-to-binary converter (reverse double-dabble).
// One conversion at a time. A start in IDLE captures the digits; 16 shift/correct
// iterations then produce the binary value. Digits above 9 are flagged at once.
module bcd_binario_seq #(
  parameter int unsigned OUT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       unidade,
  input  logic [3:0]       dezena,
  input  logic [3:0]       centena,
  input  logic [3:0]       milhar,
  output logic [OUT_W-1:0] binario,
  output logic             busy,
  output logic             done,
  output logic             erro
);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e           state_q, state_d;
  logic [15:0]      b_q, b_d;      // BCD digits being drained
  logic [15:0]      r_q, r_d;      // binary result being filled from the top
  logic [3:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0] binario_q, binario_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             erro_q, erro_d;

  logic [15:0] digits;
  logic        digit_bad;
  logic        last;
  logic [31:0] shifted;
  logic [15:0] b_corr;

  assign digits    = {milhar, centena, dezena, unidade};
  assign digit_bad = (milhar > 4'd9) || (centena > 4'd9) || (dezena > 4'd9) || (unidade > 4'd9);
  assign last      = (cnt_q == 4'd15);
  assign shifted   = {b_q, r_q} >> 1;

  // After the right shift, a digit that received a carried-in weight-8 bit gets -3
  always_comb begin
    b_corr = shifted[31:16];
    for (int i = 0; i < 4; i++) begin
      if (shifted[16+4*i +: 4] >= 4'd8) begin
        b_corr[4*i +: 4] = shifted[16+4*i +: 4] - 4'd3;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      b_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      binario_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      binario_q <= binario_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      erro_q    <= erro_d;
    end
  end

  // Next state: invalid digits never enter CONV
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start && !digit_bad) state_d = StConv;
      StConv: if (last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next datapath and flag values; done defaults low so it pulses for one cycle
  always_comb begin
    b_d       = b_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    binario_d = binario_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    erro_d    = erro_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          b_d    = digits;
          r_d    = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          erro_d = 1'b0;
          if (digit_bad) begin
            binario_d = '0;
            erro_d    = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
          end
        end
      end
      StConv: begin
        b_d   = b_corr;
        r_d   = shifted[15:0];
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          binario_d = OUT_W'(shifted[15:0]);
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs come straight from registers
  always_comb begin
    binario = binario_q;
    busy    = busy_q;
    done    = done_q;
    erro    = erro_q;
  end

endmodule
